// File: rtl/serdes_word_aligner.sv
// serdes_word_aligner: finds the bit offset of PATTERN across 8-bit word
// boundaries from a 1:8 deserializer, confirms it over LOCK_COUNT words and
// then emits re-aligned payload words with one cycle of latency.
// Optional macro SERDES_ALIGN_TIMEOUT_EN builds the search timeout counter;
// without it search_timeout is tied low.
//
// state   | meaning
// SEARCH  | scanning all 8 offsets for PATTERN
// CONFIRM | candidate offset found, counting consecutive matches
// LOCKED  | offset fixed, payload words forwarded
module serdes_word_aligner #(
  parameter logic [7:0] PATTERN       = 8'h5C,
  parameter int         LOCK_COUNT    = 4,
  parameter int         TIMEOUT_WORDS = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       relock,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       locked,
  output logic [2:0] offset,
  output logic       search_timeout
);

  typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;

  localparam logic [3:0] LOCK_CNT4 = 4'(LOCK_COUNT);

  state_t     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [2:0] offset_q, offset_d;
  logic [7:0] prev_word_q, prev_word_d;
  logic       prev_ok_q, prev_ok_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;

  logic [15:0] window;
  logic [7:0]  cand [8];
  logic        hit;
  logic [2:0]  hit_idx;
  logic [7:0]  cand_sel;

  // Candidate words at every bit offset; lowest matching offset wins.
  always_comb begin
    window  = {in_data, prev_word_q};
    hit     = 1'b0;
    hit_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      cand[k] = window[k +: 8];
    end
    for (int k = 7; k >= 0; k--) begin
      if (cand[k] == PATTERN) begin
        hit     = 1'b1;
        hit_idx = 3'(k);
      end
    end
    cand_sel = cand[offset_q];
  end

  // Next-state and output logic; relock wins over any word in the same cycle.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    offset_d    = offset_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    prev_word_d = in_valid ? in_data : prev_word_q;
    prev_ok_d   = prev_ok_q | in_valid;
    if (relock) begin
      state_d   = SEARCH;
      count_d   = 4'd0;
      prev_ok_d = 1'b0;
    end else if (in_valid) begin
      case (state_q)
        SEARCH: begin
          if (prev_ok_q && hit) begin
            offset_d = hit_idx;
            count_d  = 4'd1;
            state_d  = (LOCK_COUNT > 1) ? CONFIRM : LOCKED;
          end
        end
        CONFIRM: begin
          if (cand_sel == PATTERN) begin
            count_d = count_q + 4'd1;
            if (count_d == LOCK_CNT4) state_d = LOCKED;
          end else begin
            state_d = SEARCH;
            count_d = 4'd0;
          end
        end
        LOCKED: begin
          out_valid_d = 1'b1;
          out_data_d  = cand_sel;
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      count_q     <= 4'd0;
      offset_q    <= 3'd0;
      prev_word_q <= 8'd0;
      prev_ok_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      offset_q    <= offset_d;
      prev_word_q <= prev_word_d;
      prev_ok_q   <= prev_ok_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign locked    = (state_q == LOCKED);
  assign offset    = offset_q;

`ifdef SERDES_ALIGN_TIMEOUT_EN
  localparam logic [15:0] TMO16 = 16'(TIMEOUT_WORDS);

  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_q, tmo_d;

  // Count valid words spent searching; the flag is sticky until relock/rst.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    tmo_d     = tmo_q;
    if (relock) begin
      tmo_cnt_d = 16'd0;
      tmo_d     = 1'b0;
    end else if (state_d == LOCKED && state_q != LOCKED) begin
      tmo_cnt_d = 16'd0;
    end else if (in_valid && state_q != LOCKED) begin
      if (tmo_cnt_q != 16'hFFFF) tmo_cnt_d = tmo_cnt_q + 16'd1;
      if (tmo_cnt_d >= TMO16) tmo_d = 1'b1;
    end
  end

  // Timeout registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= 16'd0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign search_timeout = tmo_q;
`else
  assign search_timeout = 1'b0;
`endif

endmodule
